alu_operand_loader: RTL and testbench
=====================================

# alu_operand_loader

Sequential front end for the lab ALU's shift stage. It collects an operand, a shift amount and a direction code from board switches one field at a time, each on a debounced load strobe. It then presents the three fields as a stable, registered bundle with a valid/ready handshake, and latches the combinational result the shift stage returns. It sits between the board I/O (switches, debounced buttons) and the shift stage; its outputs drive that stage's `data`, `shift` and `direccion` inputs directly.

## Interface
- `n`, default 15, data width; identical to the shift stage's width.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `sw`  input  n  switch value, sampled only on `load`.
- `load`  input  1  single-cycle strobe, already debounced; commits `sw` to the current field.
- `cancel`  input  1  single-cycle strobe; aborts the sequence and returns to field entry.
- `data`  output  n  registered operand to the shift stage.
- `shift`  output  3  registered shift amount.
- `direccion`  output  3  registered direction code (0 = left, nonzero = right).
- `op_valid`  output  1  the bundle is complete and awaiting acceptance.
- `op_ready`  input  1  the downstream stage accepts the bundle this cycle.
- `result`  input  n  combinational result from the shift stage.
- `result_q`  output  n  result latched at handshake.
- `done`  output  1  one-cycle pulse after a result is latched.
- `phase`  output  2  current state encoding, for LEDs.

## Operation
- State machine, `phase` encoding in brackets:
  - LOAD_DATA [0]: on `load`, `data` ← `sw`, go to LOAD_SHIFT.
  - LOAD_SHIFT [1]: on `load`, `shift` ← `sw[2:0]`, go to LOAD_DIR. Upper `sw` bits are ignored, with no saturation.
  - LOAD_DIR [2]: on `load`, `direccion` ← `sw[2:0]`, go to ISSUE.
  - ISSUE [3]: `op_valid` = 1. On `op_valid && op_ready`: `result_q` ← `result`, go to LOAD_DATA.
- `load` is ignored in ISSUE.
- `cancel` in any state: go to LOAD_DATA and drop `op_valid`. `data`, `shift`, `direccion` and `result_q` keep their values.
- `cancel` has priority over `load` and over the handshake. Simultaneous `cancel` and `op_ready` in ISSUE gives no capture and no `done`.
- Field registers change only on their own `load`. The outputs are therefore stable while `op_valid` is high.
- `op_ready` outside ISSUE has no effect.
- Reset values: state LOAD_DATA, `data`/`shift`/`direccion`/`result_q` = 0, `op_valid` = 0, `done` = 0, `phase` = 0.
- Reset mid-sequence discards every field immediately, because it is asynchronous.

## Timing
- A `load` in cycle t updates the field and state at the t→t+1 edge. A new `phase` is visible in t+1.
- `op_valid` rises in the cycle after the third `load`. It is a registered, state-decoded output with no combinational path from any input.
- Handshake in cycle h: `result` is sampled at the h→h+1 edge, and `result_q` is valid in h+1.
- `done` is high for cycle h+1 only, and `phase` = 0 in h+1.
- Minimum operation: 3 loads, then 1 ISSUE cycle if `op_ready` is held high, i.e. 4 cycles.
- `op_valid` may stay high indefinitely while `op_ready` = 0. There is no timeout.

## Configuration
- `ALU_LOADER_OPCOUNT_EN` defined: adds output `op_count` [7:0], reset 0.
  - Increments on each completed handshake, in the same edge as the `result_q` update.
  - Wraps 255→0.
  - Not incremented on a cancelled handshake.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package `alu_pkg`:
  - `loader_state_t` enum (LOAD_DATA, LOAD_SHIFT, LOAD_DIR, ISSUE) with the encodings above.
  - `SHIFT_W` = 3.
  - `OPCOUNT_W` = 8.
- Single module, no sub-module. The shift stage is instantiated beside this block by the parent, not inside it.

## Test plan
- Reset, then check all outputs are 0. Loads with `sw` = 0x1234, 0x0003, 0x0000 give `data` = 0x1234, `shift` = 3, `direccion` = 0, with `op_valid` rising one cycle after the third load.
- In ISSUE, hold `op_ready` = 0 for 5 cycles, then drive `result` = 0x11A0 and `op_ready` = 1. Check `op_valid` stays high and the outputs stay stable during the wait. `result_q` = 0x11A0 the next cycle, with `done` high exactly one cycle and `phase` = 0.
- Load `sw` = 0x7FFF as the shift field: `shift` = 7. Check that a `load` issued during ISSUE does not change `data`.
- Assert `cancel` and `op_ready` together in ISSUE: no `done`, `result_q` unchanged, `phase` = 0, and the field registers keep their values.
- Assert `rst` asynchronously while in LOAD_DIR: all outputs drop to 0 before the next clock edge.
- With `ALU_LOADER_OPCOUNT_EN` defined, run 257 operations: `op_count` = 1. One further cancelled operation leaves `op_count` = 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and widths for the lab ALU operand loader and its shift stage.
package alu_pkg;

    localparam int SHIFT_W   = 3;
    localparam int OPCOUNT_W = 8;

    // The encoding is the value shown on the phase LEDs.
    typedef enum logic [1:0] {
        LOAD_DATA  = 2'd0,
        LOAD_SHIFT = 2'd1,
        LOAD_DIR   = 2'd2,
        ISSUE      = 2'd3
    } loader_state_t;

endpackage

// File: rtl/alu_operand_loader.sv
// Collects operand, shift amount and direction from switches, then issues them to the shift stage.
// Optional macro ALU_LOADER_OPCOUNT_EN adds an 8-bit op_count of completed handshakes.
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int n = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [n-1:0]         sw,
    input  logic                 load,
    input  logic                 cancel,
    output logic [n-1:0]         data,
    output logic [SHIFT_W-1:0]   shift,
    output logic [SHIFT_W-1:0]   direccion,
    output logic                 op_valid,
    input  logic                 op_ready,
    input  logic [n-1:0]         result,
    output logic [n-1:0]         result_q,
    output logic                 done,
    output logic [1:0]           phase
`ifdef ALU_LOADER_OPCOUNT_EN
    ,
    output logic [OPCOUNT_W-1:0] op_count
`endif
);

    loader_state_t        state_reg, state_next;
    logic [n-1:0]         data_reg, data_next;
    logic [SHIFT_W-1:0]   shift_reg, shift_next;
    logic [SHIFT_W-1:0]   dir_reg, dir_next;
    logic [n-1:0]         result_reg, result_next;
    logic                 valid_reg, valid_next;
    logic                 done_reg, done_next;
    logic                 capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= LOAD_DATA;
            data_reg   <= '0;
            shift_reg  <= '0;
            dir_reg    <= '0;
            result_reg <= '0;
            valid_reg  <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            data_reg   <= data_next;
            shift_reg  <= shift_next;
            dir_reg    <= dir_next;
            result_reg <= result_next;
            valid_reg  <= valid_next;
            done_reg   <= done_next;
        end
    end

    // cancel outranks both load and the handshake; field registers hold their values.
    always_comb begin
        state_next  = state_reg;
        data_next   = data_reg;
        shift_next  = shift_reg;
        dir_next    = dir_reg;
        result_next = result_reg;
        capture     = 1'b0;
        if (cancel) begin
            state_next = LOAD_DATA;
        end else begin
            case (state_reg)
                LOAD_DATA: begin
                    if (load) begin
                        data_next  = sw;
                        state_next = LOAD_SHIFT;
                    end
                end
                LOAD_SHIFT: begin
                    if (load) begin
                        shift_next = sw[SHIFT_W-1:0];
                        state_next = LOAD_DIR;
                    end
                end
                LOAD_DIR: begin
                    if (load) begin
                        dir_next   = sw[SHIFT_W-1:0];
                        state_next = ISSUE;
                    end
                end
                ISSUE: begin
                    if (op_ready) begin
                        result_next = result;
                        capture     = 1'b1;
                        state_next  = LOAD_DATA;
                    end
                end
                default: state_next = LOAD_DATA;
            endcase
        end
        // Registered copy of the next-state decode keeps op_valid free of input paths.
        valid_next = (state_next == ISSUE);
        done_next  = capture;
    end

`ifdef ALU_LOADER_OPCOUNT_EN
    logic [OPCOUNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (capture) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign op_count = count_reg;
`endif

    assign data      = data_reg;
    assign shift     = shift_reg;
    assign direccion = dir_reg;
    assign result_q  = result_reg;
    assign op_valid  = valid_reg;
    assign done      = done_reg;
    assign phase     = state_reg;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Scoreboard bench for alu_operand_loader: stimulus queues expected bundles/results, a negedge monitor checks them.
module tb_alu_operand_loader;
    import alu_pkg::*;

    localparam int N = 15;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         sw;
    logic                 load;
    logic                 cancel;
    logic [N-1:0]         data;
    logic [SHIFT_W-1:0]   shift;
    logic [SHIFT_W-1:0]   direccion;
    logic                 op_valid;
    logic                 op_ready;
    logic [N-1:0]         result;
    logic [N-1:0]         result_q;
    logic                 done;
    logic [1:0]           phase;
`ifdef ALU_LOADER_OPCOUNT_EN
    logic [OPCOUNT_W-1:0] op_count;
`endif

    alu_operand_loader #(.n(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .load      (load),
        .cancel    (cancel),
        .data      (data),
        .shift     (shift),
        .direccion (direccion),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .result    (result),
        .result_q  (result_q),
        .done      (done),
        .phase     (phase)
`ifdef ALU_LOADER_OPCOUNT_EN
        ,
        .op_count  (op_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] d;
        logic [2:0]   s;
        logic [2:0]   r;
    } bundle_t;

    bundle_t      bq[$];
    logic [N-1:0] rq[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic fail_event(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event seen with empty scoreboard queue", name);
    endtask

    // Monitor: compares bundles when op_valid rises, holds them stable, and checks each result capture.
    bundle_t cur;
    logic    pv = 1'b0;
    logic    pd = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (op_valid && !pv) begin
                if (bq.size() == 0) begin
                    fail_event("unexpected_op_valid");
                end else begin
                    cur = bq.pop_front();
                    check("bundle_data", 32'(data), 32'(cur.d));
                    check("bundle_shift", 32'(shift), 32'(cur.s));
                    check("bundle_dir", 32'(direccion), 32'(cur.r));
                end
            end else if (op_valid) begin
                check("stable_bundle", 32'({data, shift, direccion}), 32'({cur.d, cur.s, cur.r}));
            end
            if (done) begin
                check("done_one_cycle", 32'(pd), 32'(0));
                if (rq.size() == 0) begin
                    fail_event("unexpected_done");
                end else begin
                    check("result_q", 32'(result_q), 32'(rq.pop_front()));
                    check("phase_after_hs", 32'(phase), 32'(0));
                end
            end
        end
        pv = op_valid;
        pd = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [N-1:0] v);
        sw   = v;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic handshake(input logic [N-1:0] r);
        rq.push_back(r);
        result   = r;
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] d;
        logic [2:0]   s;
        logic [2:0]   r;
        logic [N-1:0] res;
        int           budget;

        rst = 1'b1; sw = '0; load = 1'b0; cancel = 1'b0; op_ready = 1'b0; result = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("reset_outputs", 32'({data, shift, direccion, result_q, op_valid, done, phase}), 32'(0));

        // Basic load sequence
        do_load(15'h1234);
        check("phase_shift", 32'(phase), 32'(1));
        do_load(15'h0003);
        check("phase_dir", 32'(phase), 32'(2));
        check("valid_before_third", 32'(op_valid), 32'(0));
        bq.push_back('{15'h1234, 3'd3, 3'd0});
        do_load(15'h0000);
        check("valid_after_third", 32'(op_valid), 32'(1));
        check("phase_issue", 32'(phase), 32'(3));

        // Backpressure wait, then accept
        repeat (5) tick();
        check("valid_held", 32'(op_valid), 32'(1));
        handshake(15'h11A0);
        check("done_pulse", 32'(done), 32'(1));
        check("valid_dropped", 32'(op_valid), 32'(0));
        tick();
        check("done_cleared", 32'(done), 32'(0));

        // Shift field truncation and load ignored in ISSUE
        do_load(15'h2AAA);
        do_load(15'h7FFF);
        check("shift_trunc", 32'(shift), 32'(7));
        bq.push_back('{15'h2AAA, 3'd7, 3'd1});
        do_load(15'h0001);
        do_load(15'h5555);
        check("load_in_issue_data", 32'(data), 32'(15'h2AAA));
        check("load_in_issue_phase", 32'(phase), 32'(3));
        handshake(15'h0555);
        tick();

        // cancel together with op_ready in ISSUE
        do_load(15'h0F0F);
        do_load(15'h0002);
        bq.push_back('{15'h0F0F, 3'd2, 3'd5});
        do_load(15'h0005);
        result = 15'h7777; op_ready = 1'b1; cancel = 1'b1;
        tick();
        op_ready = 1'b0; cancel = 1'b0;
        check("cancel_phase", 32'(phase), 32'(0));
        check("cancel_valid", 32'(op_valid), 32'(0));
        check("cancel_done", 32'(done), 32'(0));
        check("cancel_result_q", 32'(result_q), 32'(15'h0555));
        check("cancel_fields", 32'({data, shift, direccion}), 32'({15'h0F0F, 3'd2, 3'd5}));
        tick();
        check("cancel_done_later", 32'(done), 32'(0));

        // cancel beats load in LOAD_SHIFT
        do_load(15'h0100);
        sw = 15'h0006; load = 1'b1; cancel = 1'b1;
        tick();
        load = 1'b0; cancel = 1'b0;
        check("cancel_vs_load_phase", 32'(phase), 32'(0));
        check("cancel_vs_load_shift", 32'(shift), 32'(2));

        // Asynchronous reset in LOAD_DIR
        do_load(15'h0123);
        do_load(15'h0004);
        check("pre_reset_phase", 32'(phase), 32'(2));
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", 32'({data, shift, direccion, result_q, op_valid, done, phase}), 32'(0));
`ifdef ALU_LOADER_OPCOUNT_EN
        check("async_reset_count", 32'(op_count), 32'(0));
`endif
        @(negedge clk);
        rst = 1'b0;
        tick();

        // 257 back-to-back operations with realistic shift results
        for (int i = 0; i < 257; i++) begin
            d = 15'(i * 97 + 5);
            s = 3'(i % 8);
            r = 3'(i % 3);
            res = (r == 3'd0) ? (d << s) : (d >> s);
            bq.push_back('{d, s, r});
            do_load(d);
            do_load(15'(s));
            do_load(15'(r));
            handshake(res);
        end
        tick();
`ifdef ALU_LOADER_OPCOUNT_EN
        check("op_count_wrap", 32'(op_count), 32'(1));
`endif
        bq.push_back('{15'h0042, 3'd1, 3'd0});
        do_load(15'h0042);
        do_load(15'h0001);
        do_load(15'h0000);
        result = 15'h0084; op_ready = 1'b1; cancel = 1'b1;
        tick();
        op_ready = 1'b0; cancel = 1'b0;
        tick();
`ifdef ALU_LOADER_OPCOUNT_EN
        check("op_count_cancelled", 32'(op_count), 32'(1));
`endif

        budget = 0;
        while ((bq.size() != 0 || rq.size() != 0) && budget < 10) begin
            tick();
            budget++;
        end
        check("scoreboard_drained", 32'(bq.size() + rq.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
